// File: rtl/ao_exp_seq.sv
// ao_exp_seq - multi-cycle AND-OR (sum-of-products) expansion sequencer.
//
// Evaluates one LITS-wide product term per clock through a single shared
// AND slice and OR-accumulates the results. Operands are captured at START
// so the operation in flight is immune to later input changes.
//
// Ports:
//   CLK       rising-edge clock
//   RST       synchronous reset, active-high, highest priority
//   START     begin an evaluation (sampled only in IDLE)
//   IN_VEC    literal vector, term k at [k*LITS +: LITS]
//   TERM_EN   per-term enable, disabled term contributes 0 (still costs a cycle)
//   EARLY     stop at the first true enabled term
//   BUSY      evaluation in progress
//   DONE      one-cycle completion pulse
//   Y         OR of evaluated enabled terms, held until next completion
//   TERM_HIT  index of first true enabled term, TERMS if none
//   EVAL_CNT  number of terms evaluated in the last operation
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for START; results of the last operation held
// EVAL  | evaluating term idx, one term per clock

module ao_exp_seq #(
  parameter int TERMS = 8,
  parameter int LITS  = 3,
  localparam int CW   = $clog2(TERMS + 1)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [TERMS*LITS-1:0] IN_VEC,
  input  logic [TERMS-1:0]      TERM_EN,
  input  logic                  EARLY,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  Y,
  output logic [CW-1:0]         TERM_HIT,
  output logic [CW-1:0]         EVAL_CNT
);

  typedef enum logic {
    IDLE = 1'b0,
    EVAL = 1'b1
  } state_t;

  state_t                  state, state_nx;

  logic [TERMS*LITS-1:0]   in_q, in_nx;
  logic [TERMS-1:0]        en_q, en_nx;
  logic                    early_q, early_nx;
  logic [CW-1:0]           idx, idx_nx;
  logic                    acc, acc_nx;
  logic                    hit_found, hit_found_nx;
  logic [CW-1:0]           hit_idx, hit_idx_nx;
  logic                    done_q, done_nx;
  logic                    y_q, y_nx;
  logic [CW-1:0]           hit_q, hit_nx;
  logic [CW-1:0]           cnt_q, cnt_nx;

  logic [LITS-1:0]         term_lits;
  logic                    term_en_bit;
  logic                    term_t;
  logic                    last_term;

  // Shared expander slice: select the current term's literals and enable.
  always_comb begin
    term_lits   = '0;
    term_en_bit = 1'b0;
    for (int k = 0; k < TERMS; k++) begin
      if (idx == CW'(k)) begin
        term_lits   = in_q[k*LITS +: LITS];
        term_en_bit = en_q[k];
      end
    end
  end

  assign term_t    = term_en_bit & (&term_lits);
  assign last_term = (idx == CW'(TERMS - 1));

  always_comb begin
    state_nx     = state;
    in_nx        = in_q;
    en_nx        = en_q;
    early_nx     = early_q;
    idx_nx       = idx;
    acc_nx       = acc;
    hit_found_nx = hit_found;
    hit_idx_nx   = hit_idx;
    done_nx      = 1'b0;
    y_nx         = y_q;
    hit_nx       = hit_q;
    cnt_nx       = cnt_q;

    case (state)
      IDLE: begin
        if (START) begin
          in_nx        = IN_VEC;
          en_nx        = TERM_EN;
          early_nx     = EARLY;
          idx_nx       = '0;
          acc_nx       = 1'b0;
          hit_found_nx = 1'b0;
          hit_idx_nx   = '0;
          state_nx     = EVAL;
        end
      end

      EVAL: begin
        acc_nx = acc | term_t;
        if (term_t && !hit_found) begin
          hit_found_nx = 1'b1;
          hit_idx_nx   = idx;
        end
        if (last_term || (early_q && term_t)) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
          y_nx     = acc | term_t;
          hit_nx   = hit_found_nx ? hit_idx_nx : CW'(TERMS);
          cnt_nx   = idx + CW'(1);
        end else begin
          idx_nx = idx + CW'(1);
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      in_q      <= '0;
      en_q      <= '0;
      early_q   <= 1'b0;
      idx       <= '0;
      acc       <= 1'b0;
      hit_found <= 1'b0;
      hit_idx   <= '0;
      done_q    <= 1'b0;
      y_q       <= 1'b0;
      hit_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state     <= state_nx;
      in_q      <= in_nx;
      en_q      <= en_nx;
      early_q   <= early_nx;
      idx       <= idx_nx;
      acc       <= acc_nx;
      hit_found <= hit_found_nx;
      hit_idx   <= hit_idx_nx;
      done_q    <= done_nx;
      y_q       <= y_nx;
      hit_q     <= hit_nx;
      cnt_q     <= cnt_nx;
    end
  end

  assign BUSY     = (state == EVAL);
  assign DONE     = done_q;
  assign Y        = y_q;
  assign TERM_HIT = hit_q;
  assign EVAL_CNT = cnt_q;

endmodule

// File: tb/tb_ao_exp_seq.sv
// Testbench for ao_exp_seq (TERMS=8, LITS=3). Expected results are pushed
// to a queue when an operation is started and popped by a monitor on DONE.

module tb_ao_exp_seq;

  localparam int TERMS = 8;
  localparam int LITS  = 3;
  localparam int CW    = $clog2(TERMS + 1);
  localparam int VW    = TERMS * LITS;

  logic          CLK;
  logic          RST;
  logic          START;
  logic [VW-1:0] IN_VEC;
  logic [TERMS-1:0] TERM_EN;
  logic          EARLY;
  logic          BUSY;
  logic          DONE;
  logic          Y;
  logic [CW-1:0] TERM_HIT;
  logic [CW-1:0] EVAL_CNT;

  ao_exp_seq #(.TERMS(TERMS), .LITS(LITS)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .START    (START),
    .IN_VEC   (IN_VEC),
    .TERM_EN  (TERM_EN),
    .EARLY    (EARLY),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .Y        (Y),
    .TERM_HIT (TERM_HIT),
    .EVAL_CNT (EVAL_CNT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic          y;
    logic [CW-1:0] hit;
    logic [CW-1:0] cnt;
  } res_t;

  typedef struct {
    logic [VW-1:0]    vec;
    logic [TERMS-1:0] en;
    logic             early;
    logic             y;
    logic [CW-1:0]    hit;
    logic [CW-1:0]    cnt;
  } vec_t;

  res_t exp_q[$];
  res_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every DONE pulse consumes one expected result.
  always @(negedge CLK) begin
    if (DONE === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("y", {31'd0, Y}, {31'd0, mon_e.y});
        chk("term_hit", 32'(TERM_HIT), 32'(mon_e.hit));
        chk("eval_cnt", 32'(EVAL_CNT), 32'(mon_e.cnt));
      end
    end
  end

  // Called at a negedge: present operands with START for one edge.
  task automatic start_op(input logic [VW-1:0] vec, input logic [TERMS-1:0] en,
                          input logic early, input logic ey,
                          input logic [CW-1:0] eh, input logic [CW-1:0] ec);
    res_t r;
    IN_VEC  = vec;
    TERM_EN = en;
    EARLY   = early;
    START   = 1'b1;
    r.y = ey; r.hit = eh; r.cnt = ec;
    exp_q.push_back(r);
    @(negedge CLK);
    START = 1'b0;
    chk("busy_after_start", {31'd0, BUSY}, 32'd1);
  endtask

  // Counts edges after the start edge until DONE is seen (bounded).
  task automatic wait_done(input string name, input int exp_n);
    int n;
    n = 0;
    while (DONE !== 1'b1 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    chk(name, 32'(n), 32'(exp_n));
    chk("busy_at_done", {31'd0, BUSY}, 32'd0);
  endtask

  vec_t tbl[10];
  int   dc;

  initial begin
    tbl[0] = '{24'h000007, 8'hFF, 1'b0, 1'b1, 4'd0, 4'd8};
    tbl[1] = '{24'h000007, 8'hFF, 1'b1, 1'b1, 4'd0, 4'd1};
    tbl[2] = '{24'hE00000, 8'h7F, 1'b1, 1'b0, 4'd8, 4'd8};
    tbl[3] = '{24'hE00000, 8'hFF, 1'b1, 1'b1, 4'd7, 4'd8};
    tbl[4] = '{24'hFFFFFF, 8'h00, 1'b1, 1'b0, 4'd8, 4'd8};
    tbl[5] = '{24'h000038, 8'hFF, 1'b0, 1'b1, 4'd1, 4'd8};
    tbl[6] = '{24'h000E38, 8'hFD, 1'b1, 1'b1, 4'd3, 4'd4};
    tbl[7] = '{24'h1C0006, 8'hFF, 1'b1, 1'b1, 4'd6, 4'd7};
    tbl[8] = '{24'hFFFFFF, 8'hFF, 1'b0, 1'b1, 4'd0, 4'd8};
    tbl[9] = '{24'h000000, 8'hFF, 1'b0, 1'b0, 4'd8, 4'd8};

    // Reset held two cycles with START asserted.
    RST = 1'b1; START = 1'b1; IN_VEC = 24'h000007; TERM_EN = 8'hFF; EARLY = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_busy", {31'd0, BUSY}, 32'd0);
    chk("rst_done", {31'd0, DONE}, 32'd0);
    chk("rst_y", {31'd0, Y}, 32'd0);
    chk("rst_hit", 32'(TERM_HIT), 32'd0);
    chk("rst_cnt", 32'(EVAL_CNT), 32'd0);
    RST = 1'b0; START = 1'b0;
    repeat (3) @(negedge CLK);
    chk("no_start_after_rst", {31'd0, BUSY}, 32'd0);
    chk("no_done_after_rst", 32'(done_cnt), 32'd0);

    // Table-driven operations; latency equals EVAL_CNT edges after start.
    for (int i = 0; i < 10; i++) begin
      start_op(tbl[i].vec, tbl[i].en, tbl[i].early, tbl[i].y, tbl[i].hit, tbl[i].cnt);
      wait_done($sformatf("latency_%0d", i), int'(tbl[i].cnt));
      @(negedge CLK);
      chk($sformatf("done_width_%0d", i), {31'd0, DONE}, 32'd0);
    end

    // Results hold while inputs change without START.
    IN_VEC = 24'hFFFFFF; TERM_EN = 8'hFF; EARLY = 1'b1;
    repeat (4) @(negedge CLK);
    chk("hold_y", {31'd0, Y}, 32'd0);
    chk("hold_hit", 32'(TERM_HIT), 32'd8);
    chk("hold_busy", {31'd0, BUSY}, 32'd0);

    // START re-pulsed at edge 3 with different operands is ignored.
    dc = done_cnt;
    start_op(24'h000007, 8'hFF, 1'b0, 1'b1, 4'd0, 4'd8);
    repeat (2) @(negedge CLK);
    START = 1'b1; IN_VEC = 24'h000000; TERM_EN = 8'h00; EARLY = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    wait_done("repulse_latency", 5);
    repeat (12) @(negedge CLK);
    chk("repulse_one_done", 32'(done_cnt - dc), 32'd1);
    chk("repulse_idle", {31'd0, BUSY}, 32'd0);

    // Back-to-back: START held during the DONE cycle.
    start_op(24'h000007, 8'hFF, 1'b0, 1'b1, 4'd0, 4'd8);
    wait_done("b2b_first", 8);
    start_op(24'h000038, 8'hFF, 1'b1, 1'b1, 4'd1, 4'd2);
    wait_done("b2b_second", 2);
    @(negedge CLK);
    chk("b2b_done_width", {31'd0, DONE}, 32'd0);

    // Abort at edge 4: no DONE, outputs back to reset values.
    dc = done_cnt;
    IN_VEC = 24'h000007; TERM_EN = 8'hFF; EARLY = 1'b0; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("abort_busy", {31'd0, BUSY}, 32'd0);
    chk("abort_y", {31'd0, Y}, 32'd0);
    chk("abort_hit", 32'(TERM_HIT), 32'd0);
    chk("abort_cnt", 32'(EVAL_CNT), 32'd0);
    repeat (10) @(negedge CLK);
    chk("abort_no_done", 32'(done_cnt - dc), 32'd0);
    start_op(24'h000007, 8'hFF, 1'b0, 1'b1, 4'd0, 4'd8);
    wait_done("after_abort", 8);
    repeat (3) @(negedge CLK);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
